// File: rtl/adc_regs.sv
// Successive-approximation register for the ADC front end: one comparator decision per clock, MSB first.
// Optional `result` capture register is built when ADC_REGS_RESULT_EN is defined.
module adc_regs #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             busy,
    output logic [1:0]       dbg_state
`ifdef ADC_REGS_RESULT_EN
    ,
    output logic [WIDTH-1:0] result
`endif
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] conv_code;

    assign dbg_state = state;

    // Resolve the current bit from the comparator and raise the next trial bit below it.
    always_comb begin
        conv_code = out;
        conv_code[idx] = in;
        if (idx != '0) begin
            conv_code[idx - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            out   <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            idx   <= IDX_TOP;
`ifdef ADC_REGS_RESULT_EN
            result <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (enable) begin
                        out   <= MSB_CODE;
                        idx   <= IDX_TOP;
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (!enable) begin
                        // Abort: clear the trial code so the DAC returns to a known level.
                        state <= IDLE;
                        out   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        out <= conv_code;
                        if (idx == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
`ifdef ADC_REGS_RESULT_EN
                            result <= conv_code;
`endif
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (enable) begin
                        // Back-to-back: the next MSB trial loads on the edge leaving DONE.
                        out   <= MSB_CODE;
                        idx   <= IDX_TOP;
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_regs.sv
// Self-checking bench for adc_regs: vector table for reset/startup/abort, then
// binary-search reference conversions with random targets and decisions.
module tb_adc_regs;
    localparam int W = 10;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         in = 1'b0;
    logic [W-1:0] out;
    logic         done;
    logic         busy;
    logic [1:0]   dbg_state;
`ifdef ADC_REGS_RESULT_EN
    logic [W-1:0] result;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    logic [W-1:0] one_w = 1;
    logic [W-1:0] msb_w;

    adc_regs #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in        (in),
        .out       (out),
        .done      (done),
        .busy      (busy),
        .dbg_state (dbg_state)
`ifdef ADC_REGS_RESULT_EN
        ,
        .result    (result)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: binary search. After k decisions the code holds those decisions
    // in its top k bits and a 1 in the next trial position.
    task automatic do_conversion(input bit use_target, input logic [W-1:0] target,
                                 output logic [W-1:0] final_code);
        logic [W-1:0] code;
        logic [W-1:0] trial;
        logic [W-1:0] exp;
        int busy_cnt;
        enable = 1'b1;
        in = 1'($urandom_range(0, 1));
        step();
        chk("start_out", out, msb_w);
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_state", dbg_state, ST_CONV);
        busy_cnt = busy ? 1 : 0;
        code = '0;
        for (int k = 0; k < W; k++) begin
            trial = code | (one_w << (W - 1 - k));
            in = use_target ? (target >= trial) : 1'($urandom_range(0, 1));
            if (in) code = code | (one_w << (W - 1 - k));
            step();
            exp = (k < W - 1) ? (code | (one_w << (W - 2 - k))) : code;
            chk("trial_out", out, exp);
            chk("busy", busy, (k < W - 1) ? 1 : 0);
            chk("done", done, (k == W - 1) ? 1 : 0);
            if (busy) busy_cnt++;
            if (done) last_done_cyc = cyc;
        end
        chk("busy_len", busy_cnt, W);
        if (use_target) chk("target_code", out, target);
`ifdef ADC_REGS_RESULT_EN
        chk("result_load", result, code);
`endif
        final_code = code;
    endtask

    typedef struct {
        logic         rst;
        logic         en;
        logic         cin;
        logic [W-1:0] exp_out;
        logic         exp_done;
        logic         exp_busy;
        logic [1:0]   exp_state;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [W-1:0] fc;
        logic [W-1:0] held;
        int t1;
        int gap;
        msb_w = one_w << (W - 1);

        // Reset held with enable/in high, startup sequence 0,1,1,0, then abort after 4 CONVERT edges.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 10'h000, 1'b0, 1'b0, ST_IDLE};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 10'h000, 1'b0, 1'b0, ST_IDLE};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 10'h200, 1'b0, 1'b1, ST_CONV};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 10'h100, 1'b0, 1'b1, ST_CONV};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 10'h180, 1'b0, 1'b1, ST_CONV};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 10'h1C0, 1'b0, 1'b1, ST_CONV};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 10'h1A0, 1'b0, 1'b1, ST_CONV};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0, ST_IDLE};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0, ST_IDLE};

        for (int i = 0; i < 9; i++) begin
            reset = vecs[i].rst;
            enable = vecs[i].en;
            in = vecs[i].cin;
            step();
            chk("vec_out", out, vecs[i].exp_out);
            chk("vec_done", done, vecs[i].exp_done);
            chk("vec_busy", busy, vecs[i].exp_busy);
            chk("vec_state", dbg_state, vecs[i].exp_state);
        end
`ifdef ADC_REGS_RESULT_EN
        chk("result_after_abort", result, 0);
`endif

        // Full-scale and zero-scale conversions, each followed by a return to IDLE with out held.
        do_conversion(1'b1, 10'h3FF, fc);
        enable = 1'b0;
        step();
        chk("hold_out_3ff", out, 10'h3FF);
        chk("hold_state", dbg_state, ST_IDLE);
        chk("hold_done", done, 0);
        do_conversion(1'b1, 10'h000, fc);
        enable = 1'b0;
        step();
        chk("hold_out_000", out, 10'h000);

        // Back-to-back conversions with enable held high.
        do_conversion(1'b1, 10'h2A5, fc);
        t1 = last_done_cyc;
        do_conversion(1'b1, 10'h2A5, fc);
        chk("b2b_spacing", last_done_cyc - t1, W + 1);
        chk("b2b_code", out, 10'h2A5);
        enable = 1'b0;
        step();

        // Abort after 4 CONVERT edges: result keeps the previous completion.
        enable = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            in = 1'($urandom_range(0, 1));
            step();
        end
        enable = 1'b0;
        step();
        chk("abort_out", out, 0);
        chk("abort_state", dbg_state, ST_IDLE);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
`ifdef ADC_REGS_RESULT_EN
        chk("abort_result", result, 10'h2A5);
`endif

        // Reset while resolving bit 5.
        enable = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            in = 1'b1;
            step();
        end
        reset = 1'b1;
        step();
        chk("rst_mid_out", out, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_state", dbg_state, ST_IDLE);
`ifdef ADC_REGS_RESULT_EN
        chk("rst_mid_result", result, 0);
`endif
        reset = 1'b0;
        enable = 1'b0;
        step();
        chk("post_rst_state", dbg_state, ST_IDLE);

        // Random targets and random comparator sequences with random idle gaps.
        for (int r = 0; r < 25; r++) begin
            do_conversion(1'($urandom_range(0, 1)), W'($urandom_range(0, (1 << W) - 1)), held);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                enable = 1'b0;
                in = 1'($urandom_range(0, 1));
                step();
                chk("gap_out", out, held);
                chk("gap_busy", busy, 0);
                chk("gap_done", done, 0);
                chk("gap_state", dbg_state, ST_IDLE);
`ifdef ADC_REGS_RESULT_EN
                chk("gap_result", result, held);
`endif
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
